// File: rtl/f_pc_sequencer.sv
// f_pc_sequencer -- fetch-stage PC sequencer for the 5-stage MIPS pipeline.
//
// Owns the F-stage PC and fetches one instruction at a time over a
// single-outstanding req/gnt/rvalid bus. The fetched word is held for D until
// it is accepted (stall=0). Redirect priority: reset > Req (exception entry) >
// eret > taken branch/jump. A branch keeps its delay slot: when the slot is
// still in flight, the target is parked in pend and used after the slot.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   stall                       D cannot accept an instruction this cycle
//   Req, eret, EPC              exception entry / eret and its target
//   redir_valid, redir_target   taken branch/jump resolved in D
//   ibus_req, ibus_addr         fetch request (decoded from state and PC only)
//   ibus_gnt, ibus_rvalid,
//   ibus_rdata                  bus grant / response
//   F_PC, F_instr, F_valid,
//   F_AdEL                      instruction presented to D (registered)
module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4184,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Req,
  input  logic        eret,
  input  logic [31:0] EPC,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_AdEL
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] f_instr_q, f_instr_d;
  logic        f_valid_q, f_valid_d;
  logic        f_adel_q, f_adel_d;
  logic        drop_q, drop_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        addr_ok;
  logic        flush;
  logic [31:0] flush_target;
  logic        branch;

  // Misaligned or out-of-text PCs are never put on the bus.
  assign addr_ok = (pc_q[1:0] == 2'b00) && (pc_q >= TEXT_LO) && (pc_q <= TEXT_HI);

  // Req wins over eret and ignores stall; eret and branches need D to advance.
  assign flush        = Req | (eret & ~stall);
  assign flush_target = Req ? HANDLER_PC : EPC;
  assign branch       = redir_valid & ~stall & ~flush;

  assign ibus_req  = (state_q == S_REQ) && addr_ok;
  assign ibus_addr = pc_q;

  assign F_PC    = f_pc_q;
  assign F_instr = f_instr_q;
  assign F_valid = f_valid_q;
  assign F_AdEL  = f_adel_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_pc_d        = f_pc_q;
    f_instr_d     = f_instr_q;
    f_valid_d     = f_valid_q;
    f_adel_d      = f_adel_q;
    drop_d        = drop_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;

    unique case (state_q)
      S_REQ: begin
        if (flush) begin
          pc_d      = flush_target;
          pend_d    = 1'b0;
          f_valid_d = 1'b0;
          // The old address was already on the bus; a grant this cycle
          // commits us to one response that must be thrown away.
          if (ibus_req && ibus_gnt) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else begin
          if (branch) begin
            pend_d        = 1'b1;
            pend_target_d = redir_target;
          end
          if (!addr_ok) begin
            state_d   = S_HOLD;
            f_instr_d = 32'h0;
            f_adel_d  = 1'b1;
            f_pc_d    = pc_q;
            f_valid_d = 1'b1;
          end else if (ibus_gnt) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (flush) begin
          pc_d      = flush_target;
          pend_d    = 1'b0;
          f_valid_d = 1'b0;
          if (ibus_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else begin
          if (branch) begin
            pend_d        = 1'b1;
            pend_target_d = redir_target;
          end
          if (ibus_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              f_instr_d = ibus_rdata;
              f_pc_d    = pc_q;
              f_adel_d  = 1'b0;
              f_valid_d = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          pc_d      = flush_target;
          pend_d    = 1'b0;
          f_valid_d = 1'b0;
          state_d   = S_REQ;
        end else if (!stall) begin
          // Held word is the delay slot if a branch resolves now.
          if (branch)      pc_d = redir_target;
          else if (pend_q) pc_d = pend_target_q;
          else             pc_d = f_pc_q + 32'd4;
          pend_d    = 1'b0;
          f_valid_d = 1'b0;
          state_d   = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      f_pc_q        <= RESET_PC;
      f_instr_q     <= 32'h0;
      f_valid_q     <= 1'b0;
      f_adel_q      <= 1'b0;
      drop_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_pc_q        <= f_pc_d;
      f_instr_q     <= f_instr_d;
      f_valid_q     <= f_valid_d;
      f_adel_q      <= f_adel_d;
      drop_q        <= drop_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Directed bench for f_pc_sequencer with a small bus model (grant tied to
// request, configurable response latency) and hand-computed expectations.
module tb_f_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, Req, eret, redir_valid;
  logic [31:0] EPC, redir_target;
  logic        ibus_req, ibus_gnt, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_rdata;
  logic [31:0] F_PC, F_instr;
  logic        F_valid, F_AdEL;

  int n_chk = 0;
  int n_err = 0;
  int wait_cyc = 0;

  always #5 clk = ~clk;

  f_pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .Req(Req), .eret(eret), .EPC(EPC),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .F_PC(F_PC), .F_instr(F_instr), .F_valid(F_valid), .F_AdEL(F_AdEL)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0000_3000) ? 32'h2408_0001 : {16'h2400, a[15:0]};
  endfunction

  // bus model: one outstanding fetch, response wait_cyc cycles after the
  // earliest legal (next-cycle) slot
  logic        out_q = 1'b0;
  int          cnt_q = 0;
  logic [31:0] oaddr_q = 32'h0;
  assign ibus_gnt    = ibus_req;
  assign ibus_rvalid = out_q && (cnt_q == 0);
  assign ibus_rdata  = ibus_rvalid ? mem(oaddr_q) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      if (ibus_rvalid) out_q <= 1'b0;
      if (ibus_req && ibus_gnt) begin
        out_q   <= 1'b1;
        cnt_q   <= wait_cyc;
        oaddr_q <= ibus_addr;
      end else if (out_q && cnt_q > 0) begin
        cnt_q <= cnt_q - 1;
      end
    end
  end

  logic saw_3010 = 1'b0;
  always @(negedge clk) if (F_valid && F_PC == 32'h0000_3010) saw_3010 <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_fvalid(input string tag);
    int n = 0;
    while (!F_valid && n < 20) begin tick(); n++; end
    chk(tag, F_valid, 1);
  endtask

  task automatic wait_grant(output logic [31:0] a);
    int n = 0;
    while (!(ibus_req && ibus_gnt) && n < 20) begin tick(); n++; end
    chk("grant_to", ibus_req & ibus_gnt, 1);
    a = ibus_addr;
  endtask

  initial begin
    logic [31:0] a;
    int          req_seen;
    reset = 1'b1; stall = 1'b0; Req = 1'b0; eret = 1'b0; EPC = 32'h0;
    redir_valid = 1'b0; redir_target = 32'h0;
    tick(); tick();

    // reset state
    chk("rst_fvalid", F_valid, 0);
    chk("rst_fpc", F_PC, 32'h3000);
    chk("rst_finstr", F_instr, 0);
    chk("rst_adel", F_AdEL, 0);
    chk("rst_req", ibus_req, 1);
    chk("rst_addr", ibus_addr, 32'h3000);
    reset = 1'b0;

    // zero-wait: WAIT then HOLD with F_valid in cycle 3
    tick();
    chk("c2_noreq", ibus_req, 0);
    chk("c2_fvalid", F_valid, 0);
    tick();
    chk("c3_fvalid", F_valid, 1);
    chk("c3_fpc", F_PC, 32'h3000);
    chk("c3_instr", F_instr, 32'h2408_0001);

    // stall 4 cycles in HOLD
    stall = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ibus_req) req_seen++;
      chk("stall_fvalid", F_valid, 1);
      chk("stall_instr", F_instr, 32'h2408_0001);
    end
    chk("stall_noreq", req_seen, 0);
    stall = 1'b0;
    tick();
    chk("rel_req", ibus_req, 1);
    chk("rel_addr", ibus_addr, 32'h3004);

    wait_fvalid("fv_3004");
    chk("fpc_3004", F_PC, 32'h3004);
    tick();
    chk("addr_3008", ibus_addr, 32'h3008);

    // branch while the delay slot 0x3008 waits 3 cycles on the bus
    wait_cyc = 3;
    tick();
    chk("slot_wait", ibus_req, 0);
    redir_valid = 1'b1; redir_target = 32'h3100;
    tick();
    redir_valid = 1'b0;
    wait_fvalid("fv_slot");
    chk("slot_fpc", F_PC, 32'h3008);
    chk("slot_instr", F_instr, mem(32'h3008));
    wait_cyc = 0;
    tick();
    chk("br_req", ibus_req, 1);
    chk("br_addr", ibus_addr, 32'h3100);

    // get to 0x3010, then exception while it is in WAIT
    wait_fvalid("fv_3100");
    chk("fpc_3100", F_PC, 32'h3100);
    redir_valid = 1'b1; redir_target = 32'h3010;
    tick();
    redir_valid = 1'b0;
    chk("addr_3010", ibus_addr, 32'h3010);
    wait_cyc = 2;
    tick();
    Req = 1'b1;
    tick();
    Req = 1'b0;
    wait_grant(a);
    chk("exc_addr", a, 32'h4184);
    chk("drop_3010", saw_3010, 0);
    wait_cyc = 0;
    wait_fvalid("fv_4184");
    chk("fpc_4184", F_PC, 32'h4184);
    chk("instr_4184", F_instr, mem(32'h4184));

    // top of text is legal, +4 beyond it is an address error
    redir_valid = 1'b1; redir_target = 32'h6FFC;
    tick();
    redir_valid = 1'b0;
    chk("hi_req", ibus_req, 1);
    chk("hi_addr", ibus_addr, 32'h6FFC);
    wait_fvalid("fv_6ffc");
    chk("fpc_6ffc", F_PC, 32'h6FFC);
    tick();
    chk("oor_noreq", ibus_req, 0);
    chk("oor_addr", ibus_addr, 32'h7000);
    tick();
    chk("oor_fvalid", F_valid, 1);
    chk("oor_adel", F_AdEL, 1);
    chk("oor_fpc", F_PC, 32'h7000);

    // eret is ignored while stalled
    stall = 1'b1; eret = 1'b1; EPC = 32'h3040;
    tick();
    chk("eret_stall_fv", F_valid, 1);
    chk("eret_stall_pc", F_PC, 32'h7000);

    // eret and branch together: eret wins and flushes F
    stall = 1'b0; EPC = 32'h3020; redir_valid = 1'b1; redir_target = 32'h3100;
    tick();
    eret = 1'b0; redir_valid = 1'b0;
    chk("eret_flush", F_valid, 0);
    chk("eret_req", ibus_req, 1);
    chk("eret_addr", ibus_addr, 32'h3020);
    wait_fvalid("fv_3020");
    chk("fpc_3020", F_PC, 32'h3020);

    // misaligned branch target
    redir_valid = 1'b1; redir_target = 32'h3002;
    tick();
    redir_valid = 1'b0;
    chk("mis_noreq", ibus_req, 0);
    chk("mis_addr", ibus_addr, 32'h3002);
    tick();
    chk("mis_fvalid", F_valid, 1);
    chk("mis_adel", F_AdEL, 1);
    chk("mis_instr", F_instr, 0);
    chk("mis_fpc", F_PC, 32'h3002);
    stall = 1'b1; Req = 1'b1;
    tick();
    stall = 1'b0; Req = 1'b0;
    chk("mis_exc_fv", F_valid, 0);
    chk("mis_exc_req", ibus_req, 1);
    chk("mis_exc_addr", ibus_addr, 32'h4184);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
